// File: rtl/add16_chain_seq.sv
// Multi-word add sequencer wrapped around a 16-bit ripple adder (add_16), LS word first.
// Optional subtract mode is enabled by defining ADD16_SEQ_SUB_EN (adds the 'sub' port).

module add_16 (
  input  logic        CYI,
  input  logic [15:0] OP_A,
  input  logic [15:0] OP_B,
  output logic        CYO,
  output logic [15:0] SUM
);
  logic [16:0] c;

  assign c[0] = CYI;

  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    assign SUM[gi]  = OP_A[gi] ^ OP_B[gi] ^ c[gi];
    assign c[gi+1]  = (OP_A[gi] & OP_B[gi]) | (c[gi] & (OP_A[gi] ^ OP_B[gi]));
  end

  assign CYO = c[16];
endmodule

module add16_chain_seq #(
  parameter int WORDS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        cyi_init,
`ifdef ADD16_SEQ_SUB_EN
  input  logic        sub,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        out_last,
  output logic        cyo,
  output logic        zero,
  output logic        ovf,
  output logic        busy
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      sum_q, sum_d;
  logic             last_q, last_d;
  logic             cyo_q, cyo_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             first_word;
  logic             last_word;
  logic             add_cyi;
  logic [15:0]      add_b;
  logic             add_cyo;
  logic [15:0]      add_sum;
  logic             zacc_run;
  logic             ovf_word;

  assign in_ready   = !out_valid_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign first_word = (idx_q == '0);
  assign last_word  = (idx_q == LAST_IDX);

`ifdef ADD16_SEQ_SUB_EN
  // Subtract = A + ~B + 1; the mode is latched on word 0 and reused for the rest.
  logic sub_q, sub_d, sub_eff;

  assign sub_eff = first_word ? sub : sub_q;
  assign add_b   = sub_eff ? ~op_b : op_b;
  assign add_cyi = first_word ? (sub | cyi_init) : carry_q;

  always_comb begin
    sub_d = sub_q;
    if (accept && first_word) sub_d = sub;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub_q <= 1'b0;
    else        sub_q <= sub_d;
  end
`else
  assign add_b   = op_b;
  assign add_cyi = first_word ? cyi_init : carry_q;
`endif

  add_16 u_add (add_cyi, op_a, add_b, add_cyo, add_sum);

  assign zacc_run = first_word ? 1'b1 : zacc_q;
  // Overflow uses the B actually fed to the adder, so subtract sees the inverted sign.
  assign ovf_word = (op_a[15] == add_b[15]) & (add_sum[15] != op_a[15]);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    last_d      = last_q;
    cyo_d       = cyo_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;

    if (accept) begin
      idx_d       = last_word ? '0 : idx_q + IDX_W'(1);
      carry_d     = add_cyo;
      zacc_d      = zacc_run & (add_sum == 16'h0000);
      out_valid_d = 1'b1;
      sum_d       = add_sum;
      last_d      = last_word;
      cyo_d       = last_word & add_cyo;
      zero_d      = last_word & zacc_run & (add_sum == 16'h0000);
      ovf_d       = last_word & ovf_word;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE:    if (accept && !last_word) state_d = RUN;
      RUN:     if (accept && last_word)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= 16'h0000;
      last_q      <= 1'b0;
      cyo_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      last_q      <= last_d;
      cyo_q       <= cyo_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign out_last  = last_q;
  assign cyo       = cyo_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q == RUN);
endmodule

// File: tb/tb_add16_chain_seq.sv
// Scoreboard bench for add16_chain_seq (WORDS=2): expected beats queued by a 32-bit model.
module tb_add16_chain_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cyi_init;
`ifdef ADD16_SEQ_SUB_EN
  logic        sub_in;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        out_last;
  logic        cyo;
  logic        zero;
  logic        ovf;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Beat layout: {sum, last, cyo, zero, ovf}
  logic [19:0] sb[$];
  logic [19:0] exp_beat;
  logic [19:0] got_beat;

  add16_chain_seq #(.WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cyi_init(cyi_init),
`ifdef ADD16_SEQ_SUB_EN
    .sub(sub_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .out_last(out_last),
    .cyo(cyo), .zero(zero), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic cyi, input logic s);
    logic [31:0] bb;
    logic [32:0] full;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, (s ? 1'b1 : cyi)};
    sb.push_back({full[15:0], 1'b0, 1'b0, 1'b0, 1'b0});
    sb.push_back({full[31:16], 1'b1, full[32], (full[31:0] == 32'd0),
                  ((a[31] == bb[31]) && (full[31] != a[31]))});
  endtask

  task automatic drive_word(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
    in_valid = v;
    op_a     = a;
    op_b     = b;
    cyi_init = c;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, sum, out_last, cyo, zero, ovf, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", {out_valid, sum, out_last, cyo, zero, ovf, busy});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
    $display("reset: out_valid=%b in_ready=%b busy=%b", out_valid, in_ready, busy);
  endtask

  task automatic test_add_patterns();
    logic [31:0] ta[4];
    logic [31:0] tb[4];
    logic        tc[4];
    ta = '{32'h0001_FFFF, 32'hFFFF_FFFF, 32'h7FFF_0000, 32'h1234_8000};
    tb = '{32'h0000_0001, 32'h0000_0001, 32'h0001_0000, 32'h8000_7FFF};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 4; t++) begin
      push_op(ta[t], tb[t], tc[t], 1'b0);
      for (int w = 0; w < 2; w++) begin
        drive_word(ta[t][16*w +: 16], tb[t][16*w +: 16], tc[t], 1'b1);
        step();
        exp_beat = sb.pop_front();
        got_beat = {sum, out_last, cyo, zero, ovf};
        checks++;
        if (got_beat !== exp_beat || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL add_t%0d_w%0d got=%h v=%b required=%h v=1", t, w, got_beat, out_valid, exp_beat);
        end
        $display("add op%0d word%0d sum=%h last=%b cyo=%b zero=%b ovf=%b",
                 t, w, sum, out_last, cyo, zero, ovf);
      end
    end
    drive_word(16'h0, 16'h0, 1'b0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_valid got=%b required=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    push_op(32'h0001_0005, 32'h0000_0003, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive_word(16'h0005, 16'h0003, 1'b0, 1'b1);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
    end
    drive_word(16'h0001, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      got_beat = {sum, out_last, cyo, zero, ovf};
      checks++;
      if (got_beat !== sb[0] || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got=%h rdy=%b busy=%b required=%h rdy=0 busy=1",
                 i, got_beat, in_ready, busy, sb[0]);
      end
      $display("backpressure hold cycle %0d sum=%h in_ready=%b", i, sum, in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_in_ready got=%b required=1", in_ready);
    end
    step();
    void'(sb.pop_front());
    exp_beat = sb.pop_front();
    got_beat = {sum, out_last, cyo, zero, ovf};
    checks++;
    if (got_beat !== exp_beat || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_word1 got=%h required=%h", got_beat, exp_beat);
    end
    $display("backpressure released word1 sum=%h last=%b", sum, out_last);
    drive_word(16'h0, 16'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid_op();
    push_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    drive_word(16'h0001, 16'h0001, 1'b0, 1'b1);
    step();
    exp_beat = sb.pop_front();
    got_beat = {sum, out_last, cyo, zero, ovf};
    checks++;
    if (got_beat !== exp_beat || busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_beat0 got=%h busy=%b required=%h busy=1", got_beat, busy, exp_beat);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({out_valid, sum, out_last, cyo, zero, ovf, busy} !== 22'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset got=%h rdy=%b required=0 rdy=1",
               {out_valid, sum, out_last, cyo, zero, ovf, busy}, in_ready);
    end
    $display("reset mid-op: out_valid=%b busy=%b", out_valid, busy);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push_op(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0);
    for (int w = 0; w < 2; w++) begin
      drive_word(w == 0 ? 16'h0001 : 16'h0000, w == 0 ? 16'h0001 : 16'h0000, 1'b1, 1'b1);
      step();
      exp_beat = sb.pop_front();
      got_beat = {sum, out_last, cyo, zero, ovf};
      checks++;
      if (got_beat !== exp_beat) begin
        errors++;
        $display("FAIL after_reset_w%0d got=%h required=%h", w, got_beat, exp_beat);
      end
      $display("after reset word%0d sum=%h last=%b", w, sum, out_last);
    end
    drive_word(16'h0, 16'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ra[3];
    logic [31:0] rb[3];
    for (int t = 0; t < 3; t++) begin
      ra[t] = $urandom;
      rb[t] = $urandom;
      push_op(ra[t], rb[t], 1'b0, 1'b0);
    end
    for (int t = 0; t < 3; t++) begin
      a = ra[t];
      b = rb[t];
      for (int w = 0; w < 2; w++) begin
        drive_word(a[16*w +: 16], b[16*w +: 16], 1'b0, 1'b1);
        step();
        exp_beat = sb.pop_front();
        got_beat = {sum, out_last, cyo, zero, ovf};
        checks++;
        if (got_beat !== exp_beat || out_valid !== 1'b1 || busy !== (w == 0)) begin
          errors++;
          $display("FAIL b2b_t%0d_w%0d got=%h v=%b busy=%b required=%h v=1 busy=%b",
                   t, w, got_beat, out_valid, busy, exp_beat, (w == 0));
        end
        $display("b2b op%0d word%0d sum=%h last=%b busy=%b", t, w, sum, out_last, busy);
      end
    end
    drive_word(16'h0, 16'h0, 1'b0, 1'b0);
    step();
  endtask

`ifdef ADD16_SEQ_SUB_EN
  task automatic test_sub();
    logic [31:0] a;
    logic [31:0] b;
    a = 32'h0001_0000;
    b = 32'h0000_0001;
    push_op(a, b, 1'b0, 1'b1);
    for (int w = 0; w < 2; w++) begin
      sub_in = (w == 0);
      drive_word(a[16*w +: 16], b[16*w +: 16], 1'b0, 1'b1);
      step();
      exp_beat = sb.pop_front();
      got_beat = {sum, out_last, cyo, zero, ovf};
      checks++;
      if (got_beat !== exp_beat) begin
        errors++;
        $display("FAIL sub_w%0d got=%h required=%h", w, got_beat, exp_beat);
      end
      $display("sub word%0d sum=%h last=%b cyo=%b ovf=%b", w, sum, out_last, cyo, ovf);
    end
    sub_in = 1'b0;
    drive_word(16'h0, 16'h0, 1'b0, 1'b0);
    step();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
`ifdef ADD16_SEQ_SUB_EN
    sub_in    = 1'b0;
`endif
    drive_word(16'h0, 16'h0, 1'b0, 1'b0);
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_reset();
    test_add_patterns();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
`ifdef ADD16_SEQ_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add16_chain_seq.md
# add16_chain_seq

Multi-word add sequencer that sits directly upstream and downstream of the 16-bit ripple adder `add_16`. It accepts wide operands one 16-bit word per cycle, least-significant word first, and drives the adder's `CYI`/`OP_A`/`OP_B`. It registers the adder's `SUM`/`CYO` into an output stage and chains the carry into the next word. It produces WORDS×16-bit additions with final carry, zero and signed-overflow flags, and sits between the operand-fetch stage and the writeback stage of the datapath.

## Interface
- `WORDS`, default 2: 16-bit words per operation, legal range 1..8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand word presented.
- `in_ready` out 1: sequencer can accept a word.
- `op_a` in 16: operand A word.
- `op_b` in 16: operand B word.
- `cyi_init` in 1: carry-in for word 0; sampled only on word 0.
- `out_valid` out 1: result word valid.
- `out_ready` in 1: downstream accepts the result word.
- `sum` out 16: result word.
- `out_last` out 1: result word is the final (most-significant) word.
- `cyo` out 1: carry out of the most-significant word; valid when `out_last`=1, otherwise 0.
- `zero` out 1: every result word of the operation is 0; valid when `out_last`=1, otherwise 0.
- `ovf` out 1: two's-complement overflow of the full-width add; valid when `out_last`=1, otherwise 0.
- `busy` out 1: an operation is partially accepted (state RUN).

## Operation
- Instantiates one `add_16` using its positional ports (CYI, OP_A, OP_B, CYO, SUM).
- Word counter `idx` runs 0..WORDS-1 and advances on each accepted word (`in_valid & in_ready`). It wraps to 0 after WORDS-1.
- Adder carry-in is `cyi_init` when `idx`=0, otherwise the registered carry from the previous word.
- On accept:
  - `sum` <= adder SUM.
  - Carry register <= adder CYO.
  - `out_valid` <= 1.
  - `out_last` <= (`idx`==WORDS-1).
- Zero accumulator: set to 1 at `idx`=0 and ANDed with (SUM==0) on each word. It is presented on `zero` with the last word.
- `ovf` = (op_a[15]==op_b[15]) & (SUM[15]!=op_a[15]), evaluated on the last word only.
- States:
  - IDLE: `idx`=0, `busy`=0.
  - RUN: 0<`idx`<WORDS, `busy`=1.
  - Transitions:
    - IDLE->RUN on accept when WORDS>1.
    - RUN->IDLE on accept of word WORDS-1.
    - With WORDS=1 the sequencer never leaves IDLE.
- `in_ready` = !`out_valid` | `out_ready`. This is a combinational pass-through of backpressure; there is no skid buffer.
- Output register holds `sum`/`out_last`/`cyo`/`zero`/`ovf` stable while `out_valid` & !`out_ready`.
- `out_valid` clears when the word is taken by `out_ready` and no new word is accepted in the same cycle.

## Timing
- Reset values: `out_valid`=0, `sum`=16'h0000, `out_last`=0, `cyo`=0, `zero`=0, `ovf`=0, `busy`=0, `idx`=0, carry register=0.
- After reset, `in_ready`=1.
- Latency: 1 cycle from word accept to `out_valid`.
- Throughput: 1 word/cycle while `out_ready`=1. A WORDS-word operation takes WORDS cycles; back-to-back operations have no bubble.
- Simultaneous events: output taken and a new word accepted in the same cycle means the output register reloads and `out_valid` stays 1.
- Reset mid-operation aborts the operation: `idx` returns to 0, and the next accepted word is word 0 using `cyi_init`.
- `op_a`, `op_b` and `cyi_init` need only be stable in the cycle they are accepted.

## Configuration
- `ADD16_SEQ_SUB_EN` defined:
  - Adds input port `sub` (1 bit), sampled on word 0 and held for the whole operation.
  - When `sub`=1, `op_b` is inverted into the adder on every word, and the word-0 carry-in is forced to 1 (`cyi_init` is ignored).
  - `cyo`=1 means no borrow.
  - `ovf` uses the inverted B sign bit.
- `ADD16_SEQ_SUB_EN` undefined: no `sub` port; add only.

## Test plan
- Carry chaining (WORDS=2, cyi_init=0): A=0x0001_FFFF, B=0x0000_0001.
  - Beat 0: sum=0x0000, out_last=0.
  - Beat 1: sum=0x0002, out_last=1, cyo=0, zero=0, ovf=0.
- Full wrap (WORDS=2): A=0xFFFF_FFFF, B=0x0000_0001.
  - Result 0x0000, 0x0000, with cyo=1, zero=1, ovf=0.
- Signed overflow (WORDS=2): A=0x7FFF_0000, B=0x0001_0000.
  - Result 0x0000, 0x8000, with ovf=1, cyo=0, zero=0.
- Backpressure: hold out_ready=0 with out_valid=1.
  - in_ready=0, and sum holds for 5 cycles.
  - Pending in_valid word is not consumed until out_ready=1.
- Reset mid-op: assert rst_n=0 after beat 0 of a WORDS=2 op.
  - All outputs return to reset values and busy=0.
  - Next word uses cyi_init=1: 0x0001+0x0001 gives sum=0x0003.
- With `ADD16_SEQ_SUB_EN` (WORDS=2): sub=1, A=0x0001_0000, B=0x0000_0001.
  - Result 0xFFFF, 0x0000, with cyo=1, zero=0, ovf=0.
